// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and defaults for the pipeline controller
package pipe_ctrl_pkg;

    typedef enum logic {
        PC_RUN      = 1'b0,
        PC_MDU_BUSY = 1'b1
    } pc_state_e;

    localparam int MDU_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use comparator
module hazard_detect (
    input  logic [4:0] id_r1_i,
    input  logic [4:0] id_r2_i,
    input  logic       id_r1_used_i,
    input  logic       id_r2_used_i,
    input  logic [4:0] idex_rd_i,
    input  logic       idex_load_i,
    output logic       load_use_o
);

    logic r1_hit;
    logic r2_hit;

    assign r1_hit = id_r1_used_i && (id_r1_i == idex_rd_i);
    assign r2_hit = id_r2_used_i && (id_r2_i == idex_rd_i);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use_o = idex_load_i && (idex_rd_i != 5'd0) && (r1_hit || r2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stage advance/hold/bubble sequencing for the 5-stage core
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_r1_i,
    input  logic [4:0]       id_r2_i,
    input  logic             id_r1_used_i,
    input  logic             id_r2_used_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             idex_load_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mdu_op_i,
    input  logic             mdu_done_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             idex_we_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pc_redirect_o,
    output logic             mdu_start_o,
    output logic             mdu_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MC_W = $clog2(MDU_TIMEOUT + 1);

    pc_state_e         state_q, state_d;
    logic [MC_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              load_use;
    logic              dmem_wait;

    hazard_detect u_hazard_detect (
        .id_r1_i      (id_r1_i),
        .id_r2_i      (id_r2_i),
        .id_r1_used_i (id_r1_used_i),
        .id_r2_used_i (id_r2_used_i),
        .idex_rd_i    (idex_rd_i),
        .idex_load_i  (idex_load_i),
        .load_use_o   (load_use)
    );

    assign dmem_wait = dmem_req_i && !dmem_ready_i;

    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        idex_we_o     = 1'b1;
        exmem_we_o    = 1'b1;
        memwb_we_o    = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pc_redirect_o = 1'b0;
        mdu_start_o   = 1'b0;
        mdu_timeout_o = 1'b0;
        state_d       = state_q;
        mdu_cnt_d     = mdu_cnt_q;

        if (!rst) begin
            // every stage loads a bubble so the pipe comes out of reset empty
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            state_d       = PC_RUN;
            mdu_cnt_d     = '0;
        end else if (dmem_wait) begin
            pc_we_o    = 1'b0;
            ifid_we_o  = 1'b0;
            idex_we_o  = 1'b0;
            exmem_we_o = 1'b0;
            memwb_we_o = 1'b0;
        end else if (state_q == PC_MDU_BUSY) begin
            if (mdu_done_i) begin
                state_d   = PC_RUN;
                mdu_cnt_d = '0;
            end else if (mdu_cnt_q == MC_W'(MDU_TIMEOUT)) begin
                // abort: the MDU op is replaced by a bubble and the pipe moves on
                mdu_timeout_o = 1'b1;
                exmem_flush_o = 1'b1;
                state_d       = PC_RUN;
                mdu_cnt_d     = '0;
            end else begin
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                idex_we_o     = 1'b0;
                exmem_flush_o = 1'b1;
                mdu_cnt_d     = mdu_cnt_q + MC_W'(1);
            end
        end else if (ex_mdu_op_i) begin
            mdu_start_o   = 1'b1;
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_flush_o = 1'b1;
            state_d       = PC_MDU_BUSY;
            mdu_cnt_d     = '0;
        end else if (ex_branch_taken_i) begin
            pc_redirect_o = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            pc_we_o      = 1'b0;
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PC_RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (!pc_we_o) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_r1, id_r2, idex_rd;
    logic        id_r1_used, id_r2_used, idex_load;
    logic        branch, mdu_op, mdu_done, imem_ready, dmem_req, dmem_ready;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        pc_redirect, mdu_start, mdu_timeout;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_r1_i           (id_r1),
        .id_r2_i           (id_r2),
        .id_r1_used_i      (id_r1_used),
        .id_r2_used_i      (id_r2_used),
        .idex_rd_i         (idex_rd),
        .idex_load_i       (idex_load),
        .ex_branch_taken_i (branch),
        .ex_mdu_op_i       (mdu_op),
        .mdu_done_i        (mdu_done),
        .imem_ready_i      (imem_ready),
        .dmem_req_i        (dmem_req),
        .dmem_ready_i      (dmem_ready),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .idex_we_o         (idex_we),
        .exmem_we_o        (exmem_we),
        .memwb_we_o        (memwb_we),
        .ifid_flush_o      (ifid_flush),
        .idex_flush_o      (idex_flush),
        .exmem_flush_o     (exmem_flush),
        .pc_redirect_o     (pc_redirect),
        .mdu_start_o       (mdu_start),
        .mdu_timeout_o     (mdu_timeout),
        .stall_cnt_o       (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_r1 = 5'd0; id_r2 = 5'd0; idex_rd = 5'd0;
        id_r1_used = 1'b0; id_r2_used = 1'b0; idex_load = 1'b0;
        branch = 1'b0; mdu_op = 1'b0; mdu_done = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // we = {pc,ifid,idex,exmem,memwb}, fl = {ifid,idex,exmem}, misc = {redirect,start,timeout}
    task automatic chk_out(input string tag, input logic [4:0] we, input logic [2:0] fl,
                           input logic [2:0] misc);
        #1;
        chk({tag, ".we"}, {27'd0, pc_we, ifid_we, idex_we, exmem_we, memwb_we}, {27'd0, we});
        chk({tag, ".flush"}, {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, fl});
        chk({tag, ".misc"}, {29'd0, pc_redirect, mdu_start, mdu_timeout}, {29'd0, misc});
    endtask

    initial begin
        idle();
        rst = 1'b0;
        chk_out("reset", 5'b11111, 3'b111, 3'b000);
        tick();
        tick();
        chk("reset_stall", stall_cnt, 32'd0);

        rst = 1'b1;
        chk_out("run_idle", 5'b11111, 3'b000, 3'b000);
        tick();
        chk("idle_stall", stall_cnt, 32'd0);

        // load-use on rs1
        idex_load = 1'b1; idex_rd = 5'd5; id_r1 = 5'd5; id_r1_used = 1'b1;
        chk_out("lu_r1", 5'b00111, 3'b010, 3'b000);
        tick();
        chk("lu_stall", stall_cnt, 32'd1);

        idex_rd = 5'd0; id_r1 = 5'd0;
        chk_out("lu_x0", 5'b11111, 3'b000, 3'b000);
        tick();
        chk("lu_x0_stall", stall_cnt, 32'd1);

        idex_rd = 5'd7; id_r1 = 5'd3; id_r2 = 5'd7; id_r2_used = 1'b0;
        chk_out("lu_r2_unused", 5'b11111, 3'b000, 3'b000);
        id_r2_used = 1'b1;
        chk_out("lu_r2", 5'b00111, 3'b010, 3'b000);
        tick();
        chk("lu_r2_stall", stall_cnt, 32'd2);

        // branch beats load-use
        idle();
        branch = 1'b1; idex_load = 1'b1; idex_rd = 5'd5; id_r1 = 5'd5; id_r1_used = 1'b1;
        chk_out("branch_lu", 5'b11111, 3'b110, 3'b100);
        tick();
        chk("branch_stall", stall_cnt, 32'd2);

        idle();
        imem_ready = 1'b0;
        chk_out("fetch_wait", 5'b01111, 3'b100, 3'b000);
        tick();
        idex_load = 1'b1; idex_rd = 5'd9; id_r2 = 5'd9; id_r2_used = 1'b1;
        chk_out("lu_fetch", 5'b00111, 3'b010, 3'b000);
        tick();
        chk("fetch_stall", stall_cnt, 32'd4);

        // data wait suppresses an MDU launch
        idle();
        mdu_op = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        chk_out("dwait_launch", 5'b00000, 3'b000, 3'b000);
        tick();
        chk("dwait_stall", stall_cnt, 32'd5);

        // MDU with done on 4th busy cycle
        dmem_req = 1'b0; dmem_ready = 1'b1;
        chk_out("mdu_start", 5'b00011, 3'b001, 3'b010);
        tick();
        for (int i = 1; i <= 3; i++) begin
            chk_out($sformatf("mdu_busy%0d", i), 5'b00011, 3'b001, 3'b000);
            tick();
        end
        mdu_done = 1'b1;
        chk_out("mdu_done", 5'b11111, 3'b000, 3'b000);
        tick();
        chk("mdu_stall", stall_cnt, 32'd9);
        idle();
        chk_out("mdu_after", 5'b11111, 3'b000, 3'b000);
        tick();

        // MDU timeout
        mdu_op = 1'b1;
        chk_out("to_start", 5'b00011, 3'b001, 3'b010);
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk_out($sformatf("to_busy%0d", i), 5'b00011, 3'b001, 3'b000);
            tick();
        end
        #1;
        chk("to_pulse", {31'd0, mdu_timeout}, 32'd1);
        chk("to_exmem_flush", {31'd0, exmem_flush}, 32'd1);
        chk("to_idex_we", {31'd0, idex_we}, 32'd1);
        chk("to_start_low", {31'd0, mdu_start}, 32'd0);
        tick();
        mdu_op = 1'b0;
        chk_out("to_after", 5'b11111, 3'b000, 3'b000);
        tick();

        // data wait mid-busy freezes the busy counter
        mdu_op = 1'b1;
        chk_out("dm_start", 5'b00011, 3'b001, 3'b010);
        tick();
        for (int i = 1; i <= 2; i++) begin
            chk_out($sformatf("dm_busy%0d", i), 5'b00011, 3'b001, 3'b000);
            tick();
        end
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk_out($sformatf("dm_wait%0d", i), 5'b00000, 3'b000, 3'b000);
            tick();
        end
        dmem_req = 1'b0; dmem_ready = 1'b1;
        for (int i = 3; i <= 7; i++) begin
            chk_out($sformatf("dm_busy%0d", i), 5'b00011, 3'b001, 3'b000);
            tick();
        end
        mdu_done = 1'b1;
        chk_out("dm_done", 5'b11111, 3'b000, 3'b000);
        tick();
        idle();
        chk_out("dm_after", 5'b11111, 3'b000, 3'b000);
        tick();

        // reset mid-MDU
        mdu_op = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_out("rst_mdu", 5'b11111, 3'b111, 3'b000);
        tick();
        rst = 1'b1;
        chk("rst_mdu_stall", stall_cnt, 32'd0);
        mdu_op = 1'b0; mdu_done = 1'b1;
        chk_out("stray_done", 5'b11111, 3'b000, 3'b000);
        tick();
        mdu_done = 1'b0;
        chk_out("post_rst_run", 5'b11111, 3'b000, 3'b000);
        chk("post_rst_stall", stall_cnt, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Consumes hazard information from ID, EX and MEM and drives per-register write-enable and flush signals for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles load-use stalls, taken-branch flushes, instruction- and data-memory wait states, and multi-cycle MDU (mul/div) operations issued from EX. Register forwarding stays in the EX stage and is out of scope here; this block only decides when stages advance, hold or bubble.

## Interface
- `MDU_TIMEOUT`, 64: maximum MDU busy cycles before forced abort.
- `CNT_W`, 32: width of the stall-cycle counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `id_r1_i`, `id_r2_i`  in  5 each  source registers of the instruction in ID.
- `id_r1_used_i`, `id_r2_used_i`  in  1 each  the source is actually read.
- `idex_rd_i`  in  5  destination of the instruction in EX.
- `idex_load_i`  in  1  EX instruction is a load.
- `ex_branch_taken_i`  in  1  EX resolved a taken branch or jump.
- `ex_mdu_op_i`  in  1  EX instruction is an MDU operation.
- `mdu_done_i`  in  1  MDU result valid, single-cycle pulse.
- `imem_ready_i`  in  1  instruction fetch completes this cycle.
- `dmem_req_i`, `dmem_ready_i`  in  1 each  MEM stage access pending / completing.
- `pc_we_o`, `ifid_we_o`, `idex_we_o`, `exmem_we_o`, `memwb_we_o`  out  1 each  stage register enables.
- `ifid_flush_o`, `idex_flush_o`, `exmem_flush_o`  out  1 each  load a bubble (NOP, all write-backs off).
- `pc_redirect_o`  out  1  PC loads the branch target.
- `mdu_start_o`  out  1  one-cycle MDU launch pulse.
- `mdu_timeout_o`  out  1  one-cycle pulse on MDU abort.
- `stall_cnt_o`  out  `CNT_W`  count of cycles with `pc_we_o`=0.

## Operation
- FSM states: `RUN`, `MDU_BUSY`. Busy counter `mdu_cnt` counts 0..`MDU_TIMEOUT`.
- Default in `RUN`: all `*_we_o`=1, all flushes, `pc_redirect_o` and `mdu_start_o`=0.
- Conditions are evaluated in priority order; the first true condition applies.
  1. **Data-memory wait** (`dmem_req_i & !dmem_ready_i`, either state): all `*_we_o`=0, no flushes, FSM and `mdu_cnt` hold. `mdu_start_o` is suppressed and becomes eligible again after the wait.
  2. **`MDU_BUSY`**:
     - While `mdu_done_i`=0: `pc`/`ifid`/`idex` enables are 0, `exmem_flush_o`=1, `memwb_we_o`=1 (older instructions drain). Increment `mdu_cnt`.
     - On `mdu_done_i`: all enables 1, next state `RUN`, clear `mdu_cnt`.
     - If `mdu_cnt`=`MDU_TIMEOUT` with no done: pulse `mdu_timeout_o`, go to `RUN`, clear `mdu_cnt`, `exmem_flush_o`=1, `idex_we_o`=1. The MDU instruction is dropped.
  3. **MDU launch** (`RUN & ex_mdu_op_i`): `mdu_start_o`=1, same hold/bubble pattern as busy, next state `MDU_BUSY`.
  4. **Taken branch** (`ex_branch_taken_i`): `pc_redirect_o`=1, `pc_we_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1.
  5. **Load-use**: `idex_load_i`, `idex_rd_i`≠0, and (`id_r1_used_i & id_r1_i==idex_rd_i` or `id_r2_used_i & id_r2_i==idex_rd_i`). Drive `pc_we_o`=0, `ifid_we_o`=0, `idex_flush_o`=1.
  6. **Fetch wait** (`!imem_ready_i`): `pc_we_o`=0, `ifid_flush_o`=1. Later stages advance.
- Load-use and fetch wait can apply together; rule 5 takes precedence for IF/ID (hold, not flush).
- `stall_cnt_o` increments each cycle `pc_we_o`=0 outside reset and wraps modulo 2^`CNT_W`.

## Timing
- Hazard outputs are combinational from inputs and state within the same cycle. There is no added latency.
- `mdu_start_o` is high exactly one cycle per MDU instruction.
- The earliest `mdu_done_i` the FSM accepts is the cycle after the start pulse. A done pulse arriving in `RUN` is ignored.
- MDU instruction occupancy of EX = 1 (start) + N busy cycles, where done arrives on busy cycle N. The pipeline advances on the done cycle.
- During reset (`rst`=0):
  - all `*_we_o`=1 and all flushes=1, so bubbles propagate;
  - `pc_redirect_o`, `mdu_start_o`, `mdu_timeout_o`=0;
  - FSM goes to `RUN`, `mdu_cnt`=0, `stall_cnt_o`=0.
- Reset while in `MDU_BUSY` abandons the operation with no timeout pulse.

## Structure
- Add to `define.v`: state encodings `PC_RUN` and `PC_MDU_BUSY`, plus the default `MDU_TIMEOUT`.
- One sub-module, `hazard_detect`: purely combinational load-use comparator producing `load_use`. The FSM, priority logic and counters stay in `pipe_ctrl`.

## Test plan
- **Load-use:** `idex_load_i`=1, `idex_rd_i`=5, `id_r1_i`=5, `id_r1_used_i`=1 → `pc_we_o`=0, `ifid_we_o`=0, `idex_flush_o`=1 for one cycle; `stall_cnt_o` +1. Repeating with `idex_rd_i`=0 → no stall.
- **Branch:** `ex_branch_taken_i`=1 together with a load-use match → `pc_redirect_o`=1, `ifid_flush_o`=`idex_flush_o`=1, `pc_we_o`=1.
- **MDU:** `ex_mdu_op_i`=1, done on the 4th busy cycle → `mdu_start_o` for 1 cycle; `pc`/`ifid`/`idex` enables 0 for 4 cycles; all enables 1 on the done cycle; `stall_cnt_o`=4; state back to `RUN`.
- **MDU timeout:** `MDU_TIMEOUT`=8, no done → `mdu_timeout_o` pulses when `mdu_cnt`=8, then `RUN` with `exmem_flush_o`=1.
- **Data wait during MDU:** `dmem_req_i`=1, `dmem_ready_i`=0 for 3 cycles mid-`MDU_BUSY` → all enables 0 and `mdu_cnt` frozen for those 3 cycles; a done pulse afterwards completes normally.
- **Reset mid-MDU:** `rst`=0 for 1 cycle in `MDU_BUSY` → `RUN`, counters 0, no `mdu_timeout_o`; a subsequent stray `mdu_done_i` is ignored.
